debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised N-channel push-button conditioner. It is the successor to the single-channel debouncer that the board top currently instantiates once per KEY.
- Per channel it provides:
  - 2-FF synchronisation of the asynchronous input
  - a counter-based glitch filter
  - a stable level, plus 1-cycle press and release pulses
  - a long-press pulse, and optional auto-repeat pulses while the button stays held
- Sits between the board KEY pins and the Top control FSM in the 12 MHz domain. One instance replaces the four separate debouncer instances.

Parameters:
- N_CH, 4, number of independent channels.
- ACTIVE_LOW, 1, 1 = input low means pressed (DE2-115 KEY); 0 = input high means pressed.
- STABLE_CNT, 120000, consecutive cycles of a new synchronised value needed before the stable level flips (10 ms at 12 MHz). Must be >= 1.
- LONG_CNT, 6000000, cycles the button must stay stably pressed before o_long fires (0.5 s). Must be >= 1.
- REPEAT_CNT, 1200000, period between o_repeat pulses after o_long (0.1 s). Must be >= 1.

Ports:
- i_clk  in  1  system clock (12 MHz PLL output).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_in  in  N_CH  raw asynchronous button inputs.
- i_repeat_en  in  N_CH  per-channel auto-repeat enable; sampled every cycle.
- o_level  out  N_CH  debounced pressed level (1 = pressed).
- o_press  out  N_CH  1-cycle pulse on a debounced press.
- o_release  out  N_CH  1-cycle pulse on a debounced release.
- o_long  out  N_CH  1-cycle pulse when the press has been held LONG_CNT cycles.
- o_repeat  out  N_CH  1-cycle pulse every REPEAT_CNT cycles after o_long, while repeat is enabled.

Behaviour:
- Reset (async assert, sync release):
  - sync FFs load the released value; stable level = released; all counters = 0; FSM = IDLE.
  - All outputs = 0.
- Normalisation: pressed = ACTIVE_LOW ? ~i_in : i_in. Normalisation is applied before the synchroniser.
- Synchroniser: 2 flops per channel. Sync delay is 2 cycles.
- Filter:
  - flt_cnt increments each cycle while sync != stable, and clears to 0 on any cycle where sync == stable.
  - When sync != stable and flt_cnt == STABLE_CNT-1: stable <= sync and flt_cnt <= 0.
  - Any glitch shorter than STABLE_CNT cycles is rejected; partial counts are discarded.
- Latency: a clean edge on i_in changes o_level exactly 2+STABLE_CNT cycles later. o_press / o_release assert in the same cycle o_level changes. All outputs are registered.
- Per-channel hold FSM, with hold_cnt of width $clog2(max(LONG_CNT,REPEAT_CNT)+1):
  - IDLE: on stable rising -> o_press=1, hold_cnt=0, go PRESSED.
  - PRESSED: hold_cnt++ each cycle. At hold_cnt == LONG_CNT-1 -> o_long=1, hold_cnt=0, go HELD.
  - HELD:
    - If i_repeat_en: hold_cnt++. At REPEAT_CNT-1 -> o_repeat=1, hold_cnt wraps to 0.
    - If !i_repeat_en: hold_cnt held at 0. Re-enabling restarts a full REPEAT_CNT period.
  - Any state on stable falling -> o_release=1, hold_cnt=0, go IDLE. Release has priority over long/repeat in the same cycle; no o_long or o_repeat is emitted that cycle.
- Pulse exclusivity: o_press, o_long and o_repeat are never high together on one channel. With LONG_CNT=1, o_long fires the cycle after o_press.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Reset mid-press: everything clears. If the button is still held after reset release, a fresh o_press fires 2+STABLE_CNT cycles later.
- Counters never overflow: every counter compares against a constant that is <= its maximum value.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRESSED, HELD} hold_state_t
  - function cnt_w(int max) returning $clog2(max+1)
- Sub-module debounce_channel contains the synchroniser, filter and hold FSM for one bit. debounce_bank is a generate loop over N_CH plus ACTIVE_LOW normalisation.

Test Plan:
All scenarios use N_CH=4, ACTIVE_LOW=1, STABLE_CNT=4, LONG_CNT=20, REPEAT_CNT=8.
- Clean press: i_in[0] 1->0 at cycle 0 and held -> o_level[0] and o_press[0] rise at cycle 6; o_press[0] high 1 cycle only; other channels stay 0.
- Glitch rejection: i_in[1] low for 3 cycles, then high -> no o_press, o_level[1] stays 0. A 4-cycle low pulse produces o_press at +6 and o_release 4 cycles after o_press.
- Long + repeat: hold i_in[2] low with i_repeat_en[2]=1 -> o_press at 6, o_long at 26, o_repeat at 34, 42, 50. Release -> o_release with no further repeats.
- Repeat disabled mid-hold: drop i_repeat_en[2] at cycle 36 -> no repeat at 42. Re-enable at 60 -> next o_repeat at 68.
- Simultaneous: all four channels pressed at cycle 0 -> o_press=4'b1111 at cycle 6. Release ch3 so that it takes effect on the same cycle ch3's o_long would fire -> only o_release[3]; o_long still fires on ch0-2.
- Reset mid-hold: assert i_rst_n=0 at cycle 15 with buttons held -> all outputs 0 immediately (async). Deassert -> o_press again 6 cycles after release of reset.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button conditioner bank.
// Holds the hold-FSM state encoding and the counter width helper.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      HELD
   } hold_state_t;

   // Bits needed for a counter that must be able to hold the value max.
   function automatic int cnt_w(input int max);
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned button: 2-FF synchroniser, run-length glitch filter and
// hold FSM producing press/release/long/repeat pulses, all registered.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CNT = 120000,
   parameter int LONG_CNT   = 6000000,
   parameter int REPEAT_CNT = 1200000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pressed,
   input  logic i_repeat_en,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int FLT_W    = cnt_w(STABLE_CNT);
   localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
   localparam int HOLD_W   = cnt_w(HOLD_MAX);

   localparam logic [FLT_W-1:0]  FLT_LAST    = FLT_W'(STABLE_CNT - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CNT - 1);
   localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CNT - 1);

   logic              sync1_reg;
   logic              sync2_reg;
   logic              stable_reg, stable_next;
   logic [FLT_W-1:0]  flt_cnt_reg, flt_cnt_next;
   hold_state_t       state_reg, state_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic              press_reg, press_next;
   logic              rel_reg, rel_next;
   logic              long_reg, long_next;
   logic              rpt_reg, rpt_next;
   logic              rise_evt;
   logic              fall_evt;

   // Filter: the events fire on the edge where stable_reg flips, so the
   // pulses below land in the same cycle as the new level.
   always_comb begin
      stable_next  = stable_reg;
      flt_cnt_next = '0;
      rise_evt     = 1'b0;
      fall_evt     = 1'b0;
      if (sync2_reg != stable_reg) begin
         if (flt_cnt_reg == FLT_LAST) begin
            stable_next = sync2_reg;
            rise_evt    = sync2_reg;
            fall_evt    = ~sync2_reg;
         end else begin
            flt_cnt_next = flt_cnt_reg + 1'b1;
         end
      end
   end

   // Release wins over any long/repeat that would coincide with it.
   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      press_next    = 1'b0;
      rel_next      = 1'b0;
      long_next     = 1'b0;
      rpt_next      = 1'b0;
      if (fall_evt) begin
         rel_next      = 1'b1;
         hold_cnt_next = '0;
         state_next    = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (rise_evt) begin
                  press_next    = 1'b1;
                  hold_cnt_next = '0;
                  state_next    = PRESSED;
               end
            end
            PRESSED: begin
               if (hold_cnt_reg == LONG_LAST) begin
                  long_next     = 1'b1;
                  hold_cnt_next = '0;
                  state_next    = HELD;
               end else begin
                  hold_cnt_next = hold_cnt_reg + 1'b1;
               end
            end
            HELD: begin
               if (!i_repeat_en) begin
                  hold_cnt_next = '0;
               end else if (hold_cnt_reg == REPEAT_LAST) begin
                  rpt_next      = 1'b1;
                  hold_cnt_next = '0;
               end else begin
                  hold_cnt_next = hold_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next    = IDLE;
               hold_cnt_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_reg    <= 1'b0;
         sync2_reg    <= 1'b0;
         stable_reg   <= 1'b0;
         flt_cnt_reg  <= '0;
         state_reg    <= IDLE;
         hold_cnt_reg <= '0;
         press_reg    <= 1'b0;
         rel_reg      <= 1'b0;
         long_reg     <= 1'b0;
         rpt_reg      <= 1'b0;
      end else begin
         sync1_reg    <= i_pressed;
         sync2_reg    <= sync1_reg;
         stable_reg   <= stable_next;
         flt_cnt_reg  <= flt_cnt_next;
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         press_reg    <= press_next;
         rel_reg      <= rel_next;
         long_reg     <= long_next;
         rpt_reg      <= rpt_next;
      end
   end

   assign o_level   = stable_reg;
   assign o_press   = press_reg;
   assign o_release = rel_reg;
   assign o_long    = long_reg;
   assign o_repeat  = rpt_reg;

endmodule

// File: rtl/debounce_bank.sv
// N-channel push-button conditioner: polarity normalisation in front of one
// independent debounce_channel per input bit.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int ACTIVE_LOW = 1,
   parameter int STABLE_CNT = 120000,
   parameter int LONG_CNT   = 6000000,
   parameter int REPEAT_CNT = 1200000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [N_CH-1:0] i_in,
   input  logic [N_CH-1:0] i_repeat_en,
   output logic [N_CH-1:0] o_level,
   output logic [N_CH-1:0] o_press,
   output logic [N_CH-1:0] o_release,
   output logic [N_CH-1:0] o_long,
   output logic [N_CH-1:0] o_repeat
);

   logic [N_CH-1:0] pressed;

   // Normalised to 1 = pressed before synchronising, so reset loads 0.
   assign pressed = (ACTIVE_LOW != 0) ? ~i_in : i_in;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         debounce_channel #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_CNT   (LONG_CNT),
            .REPEAT_CNT (REPEAT_CNT)
         ) u_ch (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_pressed   (pressed[gi]),
            .i_repeat_en (i_repeat_en[gi]),
            .o_level     (o_level[gi]),
            .o_press     (o_press[gi]),
            .o_release   (o_release[gi]),
            .o_long      (o_long[gi]),
            .o_repeat    (o_repeat[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed vector table, hand-written reset case and
// random button activity, all checked against a window-based reference model.
module tb_debounce_bank;

   localparam int N  = 4;
   localparam int SC = 4;
   localparam int LC = 20;
   localparam int RC = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] in = '1;
   logic [N-1:0] en = '0;
   logic [N-1:0] level, press, rel, lng, rpt;

   always #5 clk = ~clk;

   debounce_bank #(
      .N_CH       (N),
      .ACTIVE_LOW (1),
      .STABLE_CNT (SC),
      .LONG_CNT   (LC),
      .REPEAT_CNT (RC)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in        (in),
      .i_repeat_en (en),
      .o_level     (level),
      .o_press     (press),
      .o_release   (rel),
      .o_long      (lng),
      .o_repeat    (rpt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: the level flips once the last SC synchronised samples
   // (each two edges old) all disagree with it; hold timing is edge arithmetic.
   bit [SC+1:0] m_hist [N];
   bit [N-1:0]  m_level, m_press, m_rel, m_lng, m_rpt;
   int          m_st [N];
   int          m_press_t [N];
   int          m_mark [N];
   int          m_t;
   bit          m_flip;

   always @(posedge clk) begin
      m_press = '0; m_rel = '0; m_lng = '0; m_rpt = '0;
      if (!rst_n) begin
         m_level = '0;
         m_t     = 0;
         for (int c = 0; c < N; c++) begin
            m_hist[c] = '0; m_st[c] = 0; m_press_t[c] = 0; m_mark[c] = 0;
         end
      end else begin
         m_t++;
         for (int c = 0; c < N; c++) begin
            m_hist[c] = {m_hist[c][SC:0], ~in[c]};
            m_flip = 1'b1;
            for (int j = 2; j < SC + 2; j++)
               if (m_hist[c][j] == m_level[c]) m_flip = 1'b0;
            if (m_flip) begin
               m_level[c] = ~m_level[c];
               if (m_level[c]) begin
                  m_press[c] = 1'b1; m_st[c] = 1; m_press_t[c] = m_t;
               end else begin
                  m_rel[c] = 1'b1; m_st[c] = 0;
               end
            end else if (m_st[c] == 1) begin
               if (m_t - m_press_t[c] == LC) begin
                  m_lng[c] = 1'b1; m_st[c] = 2; m_mark[c] = m_t;
               end
            end else if (m_st[c] == 2) begin
               if (!en[c]) m_mark[c] = m_t;
               else if (m_t - m_mark[c] == RC) begin
                  m_rpt[c] = 1'b1; m_mark[c] = m_t;
               end
            end
         end
      end
   end

   typedef struct {
      int          sc;
      int          cyc;
      logic [3:0]  in;
      logic [3:0]  en;
      logic [19:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [19:0] outs();
      return {level, press, rel, lng, rpt};
   endfunction

   task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h exp=%h (lvl,prs,rel,lng,rpt)", name, $time, got, exp);
      end
   endtask

   task automatic check_model();
      logic [19:0] expv;
      expv = rst_n ? {m_level, m_press, m_rel, m_lng, m_rpt} : 20'h0;
      check("model", outs(), expv);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in    = '1;
      en    = '0;
      repeat (3) next_cycle();
      rst_n = 1'b1;
   endtask

   function automatic void add(input int sc, input int cyc, input logic [3:0] i,
                               input logic [3:0] e, input logic [3:0] lv,
                               input logic [3:0] pr, input logic [3:0] rl,
                               input logic [3:0] lg, input logic [3:0] rp);
      vec_t v;
      v.sc = sc; v.cyc = cyc; v.in = i; v.en = e;
      v.exp = {lv, pr, rl, lg, rp};
      tbl.push_back(v);
   endfunction

   int idx;
   int rem [N];

   initial begin
      // sc0: clean press ch0, long/repeat ch2, repeat disable/enable, release
      add(0,  0, 4'b1010, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0,  5, 4'b1010, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0,  6, 4'b1010, 4'b0100, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0);
      add(0,  7, 4'b1010, 4'b0100, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 25, 4'b1010, 4'b0100, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 26, 4'b1010, 4'b0100, 4'h5, 4'h0, 4'h0, 4'h5, 4'h0);
      add(0, 34, 4'b1010, 4'b0100, 4'h5, 4'h0, 4'h0, 4'h0, 4'h4);
      add(0, 36, 4'b1010, 4'b0000, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 42, 4'b1010, 4'b0000, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 60, 4'b1010, 4'b0100, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 68, 4'b1010, 4'b0100, 4'h5, 4'h0, 4'h0, 4'h0, 4'h4);
      add(0, 70, 4'b1111, 4'b0100, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 75, 4'b1111, 4'b0100, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
      add(0, 76, 4'b1111, 4'b0100, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0);
      add(0, 84, 4'b1111, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      // sc1: 3-cycle glitch rejected, 4-cycle pulse accepted on ch1
      add(1,  0, 4'b1101, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1,  3, 4'b1111, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1,  6, 4'b1111, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1,  9, 4'b1111, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1, 10, 4'b1101, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1, 14, 4'b1111, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1, 16, 4'b1111, 4'b0000, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
      add(1, 19, 4'b1111, 4'b0000, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1, 20, 4'b1111, 4'b0000, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
      add(1, 21, 4'b1111, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      // sc2: all channels together, ch3 released onto its long edge
      add(2,  0, 4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(2,  6, 4'b0000, 4'b0000, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
      add(2, 20, 4'b1000, 4'b0000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
      add(2, 25, 4'b1000, 4'b0000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
      add(2, 26, 4'b1000, 4'b0000, 4'h7, 4'h0, 4'h8, 4'h7, 4'h0);
      add(2, 27, 4'b1000, 4'b0000, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0);

      idx = 0;
      for (int sc = 0; sc < 3; sc++) begin
         do_reset();
         for (int c = 0; idx < tbl.size() && tbl[idx].sc == sc; c++) begin
            next_cycle();
            while (idx < tbl.size() && tbl[idx].sc == sc && tbl[idx].cyc == c) begin
               $display("row sc=%0d cyc=%0d out=%h exp=%h", sc, c, outs(), tbl[idx].exp);
               check($sformatf("table sc%0d c%0d", sc, c), outs(), tbl[idx].exp);
               in = tbl[idx].in;
               en = tbl[idx].en;
               idx++;
            end
         end
      end

      // Reset mid-hold: async clear, then a fresh press 6 edges after release
      do_reset();
      next_cycle();
      in = 4'b0000;
      for (int c = 1; c <= 15; c++) next_cycle();
      check("pre_reset_level", outs(), {4'hF, 16'h0});
      rst_n = 1'b0;
      #1;
      check("async_reset_clear", outs(), 20'h0);
      repeat (2) next_cycle();
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         next_cycle();
         if (k == 5) check("repress_early", outs(), 20'h0);
         if (k == 6) check("repress", outs(), {4'hF, 4'hF, 12'h0});
      end
      $display("reset-mid-hold sequence done, out=%h", outs());

      // Random button activity mixing glitches, short and long holds
      do_reset();
      for (int c = 0; c < N; c++) rem[c] = 0;
      for (int t = 0; t < 4000; t++) begin
         next_cycle();
         for (int c = 0; c < N; c++) begin
            if (rem[c] == 0) begin
               in[c]  = 1'($urandom_range(0, 1));
               rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, SC + 1)
                                                    : $urandom_range(5, 70);
            end else begin
               rem[c]--;
            end
            if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
         end
      end
      $display("random phase done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
